// File: rtl/unary_stream_decoder_if.sv
// Stream bundle for the unary decoder: per-lane unary/sign inputs and the decoded
// valid/ready output.
interface unary_stream_decoder_if #(
    parameter int unsigned LANES     = 16,
    parameter int unsigned BIT_WIDTH = 8
);
    logic                            frame_start;
    logic [LANES-1:0]                unary_in;
    logic [LANES-1:0]                sign_in;
    logic                            out_valid;
    logic                            out_ready;
    logic [LANES-1:0][BIT_WIDTH-1:0] out_data;
    logic [LANES-1:0]                out_sat;

    modport master (
        output frame_start,
        output unary_in,
        output sign_in,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_sat
    );

    modport slave (
        input  frame_start,
        input  unary_in,
        input  sign_in,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_sat
    );
endinterface

// File: rtl/unary_stream_decoder.sv
// Decodes per-lane temporal unary frames into signed two's complement words and
// queues completed vectors in a 2-entry registered output FIFO.
module unary_stream_decoder #(
    parameter int unsigned LANES     = 16,
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned SIZE      = BIT_WIDTH - 1,
    parameter int unsigned FRAME_LEN = (1 << SIZE) + 2
) (
    input  logic                  clk,
    input  logic                  reset,
    unary_stream_decoder_if.slave bus,
    output logic                  frame_err,
    output logic                  overflow
);
    localparam int unsigned FC_W  = $clog2(FRAME_LEN);
    localparam int unsigned CNT_W = SIZE + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {SIZE{1'b0}}};
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_LEN - 1);

    typedef enum logic {StIdle, StCollect} state_e;

    state_e state_q, state_d;
    logic [FC_W-1:0] fc_q, fc_d;

    logic [LANES-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_acc;
    logic [LANES-1:0]            zero_q, zero_d;
    logic [LANES-1:0]            sign_q, sign_d;

    logic [LANES-1:0][BIT_WIDTH-1:0] conv_data;
    logic [LANES-1:0]                conv_sat;

    logic [1:0]                      fifo_cnt_q, fifo_cnt_d;
    logic [LANES-1:0][BIT_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [LANES-1:0]                head_sat_q, head_sat_d, tail_sat_q, tail_sat_d;

    logic frame_err_q, frame_err_d;
    logic overflow_q, overflow_d;

    logic collecting, frame_end, short_frame, thermo_bad, push, pop, drop;

    // Frame sequencing. fc counts the cycle index within the frame; the
    // frame_start cycle is index 0, so the register holds 1 in the next cycle.
    always_comb begin
        state_d     = state_q;
        fc_d        = fc_q;
        frame_end   = 1'b0;
        short_frame = 1'b0;
        collecting  = (state_q == StCollect);
        unique case (state_q)
            StIdle: begin
                if (bus.frame_start) begin
                    state_d = StCollect;
                    fc_d    = FC_W'(1);
                end
            end
            StCollect: begin
                if (fc_q == FC_LAST) begin
                    frame_end = 1'b1;
                    if (bus.frame_start) begin
                        fc_d = FC_W'(1);
                    end else begin
                        state_d = StIdle;
                        fc_d    = '0;
                    end
                end else if (bus.frame_start) begin
                    short_frame = 1'b1;
                    fc_d        = FC_W'(1);
                end else begin
                    fc_d = fc_q + FC_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                fc_d    = '0;
            end
        endcase
    end

    // Per-lane counting, thermometer check and conversion of the final count.
    always_comb begin
        cnt_d      = cnt_q;
        zero_d     = zero_q;
        sign_d     = sign_q;
        cnt_acc    = cnt_q;
        conv_data  = '0;
        conv_sat   = '0;
        thermo_bad = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            logic [BIT_WIDTH-1:0] mag_ext;
            cnt_acc[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(bus.unary_in[i]);
            // The new frame's first bit is not judged against the discarded frame.
            if (collecting && !short_frame && bus.unary_in[i] && zero_q[i]) begin
                thermo_bad = 1'b1;
            end
            if (bus.frame_start) begin
                cnt_d[i]  = CNT_W'(bus.unary_in[i]);
                zero_d[i] = ~bus.unary_in[i];
                sign_d[i] = bus.sign_in[i];
            end else if (collecting) begin
                cnt_d[i]  = cnt_acc[i];
                zero_d[i] = zero_q[i] | ~bus.unary_in[i];
            end
            mag_ext = BIT_WIDTH'(cnt_acc[i]);
            if (!sign_q[i] && cnt_acc[i] >= CNT_MAX) begin
                conv_data[i] = BIT_WIDTH'(CNT_MAX - CNT_W'(1));
                conv_sat[i]  = 1'b1;
            end else if (sign_q[i]) begin
                conv_data[i] = -mag_ext;
            end else begin
                conv_data[i] = mag_ext;
            end
        end
    end

    // Two-entry FIFO; the head is a register so outputs hold until popped.
    always_comb begin
        fifo_cnt_d  = fifo_cnt_q;
        head_data_d = head_data_q;
        head_sat_d  = head_sat_q;
        tail_data_d = tail_data_q;
        tail_sat_d  = tail_sat_q;
        push        = frame_end;
        pop         = (fifo_cnt_q != 2'd0) && bus.out_ready;
        drop        = 1'b0;
        unique case (fifo_cnt_q)
            2'd0: begin
                if (push) begin
                    head_data_d = conv_data;
                    head_sat_d  = conv_sat;
                    fifo_cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_data_d = conv_data;
                    head_sat_d  = conv_sat;
                end else if (push) begin
                    tail_data_d = conv_data;
                    tail_sat_d  = conv_sat;
                    fifo_cnt_d  = 2'd2;
                end else if (pop) begin
                    fifo_cnt_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_sat_d  = tail_sat_q;
                    if (push) begin
                        tail_data_d = conv_data;
                        tail_sat_d  = conv_sat;
                    end else begin
                        fifo_cnt_d = 2'd1;
                    end
                end else if (push) begin
                    drop = 1'b1;
                end
            end
            default: fifo_cnt_d = 2'd0;
        endcase
        frame_err_d = frame_err_q | short_frame | thermo_bad;
        overflow_d  = overflow_q | drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            fc_q        <= '0;
            cnt_q       <= '0;
            zero_q      <= '0;
            sign_q      <= '0;
            fifo_cnt_q  <= 2'd0;
            head_data_q <= '0;
            head_sat_q  <= '0;
            tail_data_q <= '0;
            tail_sat_q  <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fc_q        <= fc_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
            fifo_cnt_q  <= fifo_cnt_d;
            head_data_q <= head_data_d;
            head_sat_q  <= head_sat_d;
            tail_data_q <= tail_data_d;
            tail_sat_q  <= tail_sat_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_valid = (fifo_cnt_q != 2'd0);
    assign bus.out_data  = head_data_q;
    assign bus.out_sat   = head_sat_q;
    assign frame_err     = frame_err_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_unary_stream_decoder.sv
// Directed bench for unary_stream_decoder: table of single-frame vectors plus
// hand sequences for back-to-back, short-frame and mid-frame reset cases.
module tb_unary_stream_decoder;
    localparam int L  = 16;
    localparam int BW = 8;
    localparam int FL = 130;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_err, overflow;

    unary_stream_decoder_if #(.LANES(L), .BIT_WIDTH(BW)) bus ();

    unary_stream_decoder #(.LANES(L), .BIT_WIDTH(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef logic [L-1:0][BW-1:0] lanes_t;

    typedef struct {
        lanes_t         ones;
        logic [L-1:0]   sign;
        logic [L-1:0]   glitch;
        lanes_t         exp_data;
        logic [L-1:0]   exp_sat;
        logic           exp_err;
    } vec_t;

    vec_t vecs[4];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t blank();
        vec_t r;
        r.ones = '0; r.sign = '0; r.glitch = '0;
        r.exp_data = '0; r.exp_sat = '0; r.exp_err = 1'b0;
        return r;
    endfunction

    function automatic lanes_t lane0(input logic [BW-1:0] val);
        lanes_t r;
        r = '0;
        r[0] = val;
        return r;
    endfunction

    // Drive frame cycle indices k0..k1; lane i is high for k < ones[i], plus one
    // stray high bit at k = ones[i]+1 when glitch[i] is set.
    task automatic frame_cycles(input lanes_t ones, input logic [L-1:0] sign,
                                input logic [L-1:0] glitch, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            bus.frame_start = (k == 0);
            bus.sign_in = sign;
            for (int i = 0; i < L; i++) begin
                bus.unary_in[i] = (k < int'(ones[i])) || (glitch[i] && k == int'(ones[i]) + 1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        bus.frame_start = 1'b0;
        bus.unary_in = '0;
        bus.sign_in = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.unary_in = '0;
        bus.sign_in = '0;
        bus.out_ready = 1'b0;

        // Vector table with hand-computed results.
        vecs[0] = blank();
        vecs[0].ones[0] = 8'd5;
        vecs[0].sign[1] = 1'b1;
        vecs[0].exp_data[0] = 8'h05;

        vecs[1] = blank();
        vecs[1].ones[2] = 8'd128; vecs[1].sign[2] = 1'b1; vecs[1].exp_data[2] = 8'h80;
        vecs[1].ones[4] = 8'd128; vecs[1].exp_data[4] = 8'h7F; vecs[1].exp_sat[4] = 1'b1;
        vecs[1].ones[5] = 8'd130; vecs[1].exp_data[5] = 8'h7F; vecs[1].exp_sat[5] = 1'b1;
        vecs[1].ones[6] = 8'd3;   vecs[1].sign[6] = 1'b1; vecs[1].exp_data[6] = 8'hFD;

        vecs[2] = blank();
        vecs[2].ones[3] = 8'd2; vecs[2].glitch[3] = 1'b1; vecs[2].exp_data[3] = 8'h03;
        vecs[2].exp_err = 1'b1;
        vecs[2].ones[7] = 8'd127; vecs[2].sign[7] = 1'b1; vecs[2].exp_data[7] = 8'h81;
        vecs[2].ones[15] = 8'd1; vecs[2].exp_data[15] = 8'h01;

        vecs[3] = blank();
        vecs[3].ones[0] = 8'd129; vecs[3].sign[0] = 1'b1; vecs[3].exp_data[0] = 8'h80;
        vecs[3].ones[8] = 8'd100; vecs[3].exp_data[8] = 8'h64;
        vecs[3].ones[9] = 8'd64;  vecs[3].sign[9] = 1'b1; vecs[3].exp_data[9] = 8'hC0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            do_reset();
            check($sformatf("v%0d_reset_state", v),
                  {bus.out_valid, frame_err, overflow, bus.out_sat, bus.out_data}, '0);
            bus.out_ready = 1'b0;
            frame_cycles(vecs[v].ones, vecs[v].sign, vecs[v].glitch, 0, 2);
            check($sformatf("v%0d_err_before", v), frame_err, 1'b0);
            frame_cycles(vecs[v].ones, vecs[v].sign, vecs[v].glitch, 3, 3);
            check($sformatf("v%0d_err_after", v), frame_err, vecs[v].exp_err);
            frame_cycles(vecs[v].ones, vecs[v].sign, vecs[v].glitch, 4, FL - 2);
            check($sformatf("v%0d_valid_t0+129", v), bus.out_valid, 1'b0);
            frame_cycles(vecs[v].ones, vecs[v].sign, vecs[v].glitch, FL - 1, FL - 1);
            check($sformatf("v%0d_valid_t0+130", v), bus.out_valid, 1'b1);
            check($sformatf("v%0d_data", v), bus.out_data, vecs[v].exp_data);
            check($sformatf("v%0d_sat", v), bus.out_sat, vecs[v].exp_sat);
            check($sformatf("v%0d_err_end", v), frame_err, vecs[v].exp_err);
            idle(1);
        end

        // Three back-to-back frames with the consumer stalled.
        do_reset();
        bus.out_ready = 1'b0;
        frame_cycles(lane0(8'd1), '0, '0, 0, FL - 1);
        frame_cycles(lane0(8'd2), '0, '0, 0, FL - 1);
        frame_cycles(lane0(8'd3), '0, '0, 0, FL - 2);
        check("b2b_ovf_before", overflow, 1'b0);
        frame_cycles(lane0(8'd3), '0, '0, FL - 1, FL - 1);
        check("b2b_ovf_after", overflow, 1'b1);
        check("b2b_head1", {bus.out_valid, bus.out_data}, {1'b1, lane0(8'd1)});
        idle(3);
        check("b2b_head_stable", {bus.out_valid, bus.out_data}, {1'b1, lane0(8'd1)});
        bus.out_ready = 1'b1;
        idle(1);
        check("b2b_head2", {bus.out_valid, bus.out_data}, {1'b1, lane0(8'd2)});
        idle(1);
        check("b2b_drained", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        // Restart at fc=40: the first frame vanishes, the second decodes.
        do_reset();
        check("short_ovf_cleared", overflow, 1'b0);
        frame_cycles(lane0(8'd10), '0, '0, 0, 39);
        check("short_err_before", frame_err, 1'b0);
        frame_cycles(lane0(8'd7), 16'h0001, '0, 0, 0);
        check("short_err_set", frame_err, 1'b1);
        frame_cycles(lane0(8'd7), 16'h0001, '0, 1, FL - 2);
        check("short_no_push", bus.out_valid, 1'b0);
        frame_cycles(lane0(8'd7), 16'h0001, '0, FL - 1, FL - 1);
        check("short_second", {bus.out_valid, bus.out_data}, {1'b1, lane0(8'hF9)});
        bus.out_ready = 1'b1;
        idle(1);
        check("short_popped", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        // Reset at fc=70 with one entry held and frame_err already set.
        do_reset();
        begin
            lanes_t ones_c;
            logic [L-1:0] gl_c;
            ones_c = lane0(8'd4);
            ones_c[3] = 8'd2;
            gl_c = '0;
            gl_c[3] = 1'b1;
            frame_cycles(ones_c, '0, gl_c, 0, FL - 1);
        end
        check("rst_pre_state", {bus.out_valid, frame_err}, 2'b11);
        frame_cycles(lane0(8'd50), '0, '0, 0, 69);
        reset = 1'b1;
        #1;
        check("rst_async_clear",
              {bus.out_valid, frame_err, overflow, bus.out_sat, bus.out_data}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        frame_cycles(lane0(8'd9), '0, '0, 0, FL - 2);
        check("rst_next_latency", bus.out_valid, 1'b0);
        frame_cycles(lane0(8'd9), '0, '0, FL - 1, FL - 1);
        check("rst_next_frame", {bus.out_valid, frame_err, bus.out_data},
              {2'b10, lane0(8'h09)});
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/unary_stream_decoder.md
# unary_stream_decoder

Converts per-lane temporal unary (thermometer) bitstreams back into signed binary words. It is the decode end of the counter/comparator unary encoding used by the temporal MXU. Each lane counts ones over one data-clock frame, applies the frame's sign bit, and converts the result to two's complement. Completed frame vectors go into a 2-entry output FIFO with a valid/ready handshake, feeding downstream binary logic or test capture.

## Interface
- LANES, 16, number of parallel unary lanes
- BIT_WIDTH, 8, width of each decoded signed output word
- SIZE, BIT_WIDTH-1, magnitude bits; maximum legal count is 2^SIZE
- FRAME_LEN, (1<<SIZE)+2, cycles per frame (130 at defaults); must be ≥ 2^SIZE+1

Ports:
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- frame_start  in  1  marks the first cycle of a frame
- unary_in  in  [LANES-1:0]  one unary bit per lane, sampled every cycle
- sign_in  in  [LANES-1:0]  per-lane sign (1 = negative), sampled only when frame_start=1
- out_valid  out  1  the FIFO head holds a decoded vector
- out_ready  in  1  consumer accepts the head when out_valid & out_ready
- out_data  out  [LANES-1:0][BIT_WIDTH-1:0]  FIFO head, two's complement per lane
- out_sat  out  [LANES-1:0]  per-lane saturation flags for the head vector
- frame_err  out  1  sticky protocol-error flag; cleared only by reset
- overflow  out  1  sticky flag: a frame was dropped because the FIFO was full; cleared only by reset

## Operation
- FSM states: IDLE and COLLECT.
  - IDLE → COLLECT on frame_start.
  - COLLECT → IDLE at frame end unless frame_start is asserted that same cycle.
- Frame cycle counter `fc`:
  - loads 0 on frame_start and increments each cycle in COLLECT.
  - the frame ends when fc == FRAME_LEN-1.
- Per-lane counter `cnt` (SIZE+1 bits):
  - on frame_start, loads unary_in[i], replacing any previous value.
  - afterwards, adds unary_in[i] each COLLECT cycle.
  - saturates at 2^SIZE; it never wraps.
- Thermometer check, per lane:
  - a 1 that follows a 0 within the same frame sets frame_err.
  - the bit is still counted.
- Conversion at frame end, per lane:
  - mag = cnt.
  - sign_in=0 and mag ≥ 2^SIZE: result is 2^SIZE-1, out_sat=1.
  - sign_in=1 and mag = 2^SIZE: result is -2^SIZE, out_sat=0.
  - sign_in=1 and mag = 0: result is 0.
  - otherwise: result is ±mag.
- FIFO push at frame end:
  - if the FIFO holds 2 entries and no pop happens that cycle, the vector is dropped and overflow is set.
  - a push and a pop in the same cycle on a full FIFO both succeed.
- Short frame: frame_start while in COLLECT with fc < FRAME_LEN-1:
  - the in-progress frame is discarded with no push, and frame_err is set.
  - the new frame starts that cycle.
- frame_start in IDLE is always legal. unary_in is ignored in IDLE.
- Reset mid-frame: the partial frame and the FIFO contents are lost. The FSM returns to IDLE.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_sat=0, frame_err=0, overflow=0.
  - FSM in IDLE, FIFO empty, fc=0, cnt=0.
- A frame whose frame_start is at cycle t0 samples unary_in at t0 … t0+FRAME_LEN-1.
- The push is registered at the edge ending cycle t0+FRAME_LEN-1. out_valid=1 in cycle t0+FRAME_LEN, a latency of FRAME_LEN cycles.
- Back-to-back frames: frame_start at t0+FRAME_LEN starts the next frame without a bubble. This is the normal streaming cadence.
- out_data and out_sat are stable while out_valid=1 and out_ready=0. The FIFO head changes only on a pop.
- FIFO outputs are registered. There is no combinational path from out_ready to out_valid.
- frame_err and overflow rise in the cycle after the offending event.

## Test plan
- Lane 0 unary_in=1 for 5 cycles then 0, sign 0; lane 1 all zeros, sign 1 → out_data[0]=8'h05, out_data[1]=8'h00; out_valid rises at t0+130.
- Lane 2 ones for 128 cycles, sign 1 → 8'h80, out_sat=0. The same stream with sign 0 → 8'h7F, out_sat=1.
- Lane 3 bit pattern 1,1,0,1 then zeros → out_data[3]=8'h03 and frame_err=1 from the following cycle.
- Three back-to-back frames with out_ready=0 → two entries held, overflow=1 after the third frame end. Then out_ready=1 for 2 cycles → frames 1 and 2 pop in order and out_valid falls.
- frame_start again at fc=40 → first frame produces no output, frame_err=1. The second frame decodes correctly at its own t0+130.
- Assert reset for 1 cycle at fc=70 with one FIFO entry held → all outputs 0 immediately. The next frame decodes normally.
